// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers used by both the read-side and write-side pointer controllers.
// Gray/binary conversions work on a wide vector; callers zero-extend and truncate to pointer width.
package fifo_pkg;

  localparam int unsigned ADDRESS_WIDTH = 4;
  localparam int unsigned PTR_W         = ADDRESS_WIDTH + 1;
  localparam int unsigned MAX_W         = 32;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Zero-extended upper bits leave the prefix XOR of the real bits unchanged.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] gray);
    logic [MAX_W-1:0] bin;
    bin = gray;
    for (int i = 1; i < MAX_W; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_read_ctrl_if.sv
// Read-side FIFO control bundle: read request, synchronized write pointer in; address and status out.
interface fifo_read_ctrl_if
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = fifo_pkg::ADDRESS_WIDTH
);
  logic                     R_INC;
  logic [ADDRESS_WIDTH:0]   Rq2_Wptr;
  logic                     UF_CLR;
  logic [ADDRESS_WIDTH-1:0] R_ADDR;
  logic [ADDRESS_WIDTH:0]   R_PTR;
  logic                     R_EMPTY;
  logic                     R_ALMOST_EMPTY;
  logic [ADDRESS_WIDTH:0]   R_LEVEL;
  logic                     R_UNDERFLOW;

  // Reader and write-pointer synchronizer side.
  modport master (
    output R_INC, Rq2_Wptr, UF_CLR,
    input  R_ADDR, R_PTR, R_EMPTY, R_ALMOST_EMPTY, R_LEVEL, R_UNDERFLOW
  );

  // Read pointer controller side.
  modport slave (
    input  R_INC, Rq2_Wptr, UF_CLR,
    output R_ADDR, R_PTR, R_EMPTY, R_ALMOST_EMPTY, R_LEVEL, R_UNDERFLOW
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Async FIFO read-domain controller: binary/Gray read pointer, registered empty,
// almost-empty and fill level against the synchronized write pointer, sticky underflow.
module fifo_read_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = fifo_pkg::ADDRESS_WIDTH,
  parameter int unsigned AE_LEVEL      = 2
) (
  input logic              CLK,
  input logic              RST,
  fifo_read_ctrl_if.slave  bus
);

  localparam int unsigned PtrW = ADDRESS_WIDTH + 1;

  logic [PtrW-1:0] rbin_q, rbin_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [PtrW-1:0] level_q, level_d;
  logic [PtrW-1:0] wbin;
  logic            empty_q, empty_d;
  logic            ae_q, ae_d;
  logic            uf_q, uf_d;
  logic            rd_en;

  always_comb begin
    rd_en   = bus.R_INC & ~empty_q;
    rbin_d  = rbin_q + PtrW'(rd_en);
    rptr_d  = PtrW'(bin2gray(32'(rbin_d)));
    wbin    = PtrW'(gray2bin(32'(bus.Rq2_Wptr)));
    // Status reflects the read accepted this cycle and the current write pointer together.
    level_d = wbin - rbin_d;
    empty_d = (rptr_d == bus.Rq2_Wptr);
    ae_d    = (32'(level_d) <= AE_LEVEL);
    // A new underflow beats a simultaneous clear.
    uf_d    = (bus.R_INC & empty_q) | (uf_q & ~bus.UF_CLR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rbin_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      uf_q    <= 1'b0;
    end else begin
      rbin_q  <= rbin_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      uf_q    <= uf_d;
    end
  end

  assign bus.R_ADDR         = rbin_q[ADDRESS_WIDTH-1:0];
  assign bus.R_PTR          = rptr_q;
  assign bus.R_EMPTY        = empty_q;
  assign bus.R_ALMOST_EMPTY = ae_q;
  assign bus.R_LEVEL        = level_q;
  assign bus.R_UNDERFLOW    = uf_q;

endmodule
